rom_loader_arb: RTL and testbench

ROM_LOADER_ARB -- requirements
Module: rom_loader_arb

---
 rtl/rom_loader_arb_pkg.sv | 25 ++
 rtl/rom_loader_arb_if.sv | 46 ++++
 rtl/rom_loader_arb_wr_buf.sv | 50 +++++
 rtl/rom_loader_arb.sv | 106 ++++++++++
 tb/tb_rom_loader_arb.sv | 335 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rom_loader_arb_pkg.sv
// rom_loader_pkg: shared defaults, FSM state encoding and helpers for the
// ROM download arbiter.
// No ports (package).
package rom_loader_pkg;

  localparam logic [7:0] ROM_INDEX_DEFAULT   = 8'h00;
  localparam int         MEM_AW_DEFAULT      = 14;
  localparam int         HOLD_CYCLES_DEFAULT = 16;
  localparam int         IOCTL_AW            = 25;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_DRAIN = 3'd2,
    ST_HOLD  = 3'd3,
    ST_RUN   = 3'd4
  } state_t;

  // True when a download byte address falls inside the 2**aw byte ROM.
  function automatic logic addr_in_range(input logic [IOCTL_AW-1:0] a,
                                         input int unsigned aw);
    return (a >> aw) == '0;
  endfunction

endpackage

// File: rtl/rom_loader_arb_if.sv
// rom_loader_arb_if: groups the download (ioctl_*), core read (cpu_*) and
// shared ROM port (mem_*) signals of the ROM loader arbiter.
//   slave  : seen by rom_loader_arb
//   master : seen by the environment (download source, core, ROM)
interface rom_loader_arb_if
  import rom_loader_pkg::*;
#(
  parameter int MEM_AW = MEM_AW_DEFAULT
) ();

  logic                ioctl_download;
  logic                ioctl_wr;
  logic [IOCTL_AW-1:0] ioctl_addr;
  logic [7:0]          ioctl_dout;
  logic [7:0]          ioctl_index;
  logic                ioctl_wait;

  logic                cpu_rd_req;
  logic [MEM_AW-1:0]   cpu_addr;
  logic                cpu_rd_ack;
  logic [7:0]          cpu_rd_data;

  logic [MEM_AW-1:0]   mem_addr;
  logic                mem_we;
  logic [7:0]          mem_wdata;
  logic [7:0]          mem_rdata;

  modport slave (
    input  ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout, ioctl_index,
    output ioctl_wait,
    input  cpu_rd_req, cpu_addr,
    output cpu_rd_ack, cpu_rd_data,
    output mem_addr, mem_we, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout, ioctl_index,
    input  ioctl_wait,
    output cpu_rd_req, cpu_addr,
    input  cpu_rd_ack, cpu_rd_data,
    input  mem_addr, mem_we, mem_wdata,
    output mem_rdata
  );

endinterface

// File: rtl/rom_loader_arb_wr_buf.sv
// rom_wr_buf: one-entry download write buffer. A write is latched when the
// buffer is empty and the address is in range; the entry always drains in
// the following cycle, so full is high for exactly one cycle per byte.
//   clk_sys, reset_n : clock, async active-low reset
//   wr_en            : qualified download write strobe
//   wr_addr, wr_data : download byte address / data
//   full             : entry valid (drives mem_we and ioctl_wait)
//   buf_addr/buf_data: latched entry
//   drop             : write discarded (buffer full or address out of range)
module rom_wr_buf
  import rom_loader_pkg::*;
#(
  parameter int MEM_AW = MEM_AW_DEFAULT
) (
  input  logic                clk_sys,
  input  logic                reset_n,
  input  logic                wr_en,
  input  logic [IOCTL_AW-1:0] wr_addr,
  input  logic [7:0]          wr_data,
  output logic                full,
  output logic [MEM_AW-1:0]   buf_addr,
  output logic [7:0]          buf_data,
  output logic                drop
);

  logic in_range;
  logic latch;

  always_comb begin
    in_range = addr_in_range(wr_addr, MEM_AW);
    latch    = wr_en && !full && in_range;
    drop     = wr_en && (full || !in_range);
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      full     <= 1'b0;
      buf_addr <= '0;
      buf_data <= '0;
    end else begin
      // No stall on the ROM side: a full entry is always written out now.
      full <= latch;
      if (latch) begin
        buf_addr <= wr_addr[MEM_AW-1:0];
        buf_data <= wr_data;
      end
    end
  end

endmodule

// File: rtl/rom_loader_arb.sv
// rom_loader_arb: arbitrates a single-port ROM between a byte download
// stream and core reads, and holds the core in reset while loading.
//   clk_sys, reset_n : clock, async active-low reset
//   bus (slave)      : ioctl_* download port, cpu_* read port, mem_* ROM port
//   core_reset       : active-high core reset (low only in RUN)
//   load_err         : sticky error (out-of-range or dropped download byte)
//   byte_count       : bytes written by the current/last download (saturating)
module rom_loader_arb
  import rom_loader_pkg::*;
#(
  parameter logic [7:0] ROM_INDEX   = ROM_INDEX_DEFAULT,
  parameter int         MEM_AW      = MEM_AW_DEFAULT,
  parameter int         HOLD_CYCLES = HOLD_CYCLES_DEFAULT
) (
  input  logic            clk_sys,
  input  logic            reset_n,
  rom_loader_arb_if.slave bus,
  output logic            core_reset,
  output logic            load_err,
  output logic [MEM_AW:0] byte_count
);

  localparam int              HCW       = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HCW-1:0]  HOLD_LAST = HCW'(HOLD_CYCLES - 1);
  localparam logic [MEM_AW:0] BC_MAX    = {1'b1, {MEM_AW{1'b0}}};

  state_t            state;
  state_t            state_nxt;
  logic [HCW-1:0]    hold_cnt;
  logic              rd_pending;
  logic              rd_accept;
  logic              dl_match;
  logic              wr_en;
  logic              buf_full;
  logic              buf_drop;
  logic [MEM_AW-1:0] buf_addr;
  logic [7:0]        buf_data;

  assign dl_match = bus.ioctl_download && (bus.ioctl_index == ROM_INDEX);
  assign wr_en    = (state == ST_LOAD) && dl_match && bus.ioctl_wr;

  rom_wr_buf #(.MEM_AW(MEM_AW)) u_wr_buf (
    .clk_sys  (clk_sys),
    .reset_n  (reset_n),
    .wr_en    (wr_en),
    .wr_addr  (bus.ioctl_addr),
    .wr_data  (bus.ioctl_dout),
    .full     (buf_full),
    .buf_addr (buf_addr),
    .buf_data (buf_data),
    .drop     (buf_drop)
  );

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:  if (dl_match) state_nxt = ST_LOAD;
      ST_LOAD:  if (!dl_match) state_nxt = ST_DRAIN;
      ST_DRAIN: if (!buf_full) state_nxt = ST_HOLD;
      ST_HOLD: begin
        if (dl_match)                   state_nxt = ST_LOAD;
        else if (hold_cnt == HOLD_LAST) state_nxt = ST_RUN;
      end
      ST_RUN:   if (dl_match) state_nxt = ST_LOAD;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    core_reset = (state != ST_RUN);
    // Writes only exist in LOAD/DRAIN, so the buf_full term never blocks a
    // real read; it keeps the ROM port exclusive by construction.
    rd_accept  = (state == ST_RUN) && bus.cpu_rd_req && !rd_pending && !buf_full;

    bus.ioctl_wait  = buf_full;
    bus.mem_we      = buf_full;
    bus.mem_wdata   = buf_full ? buf_data : '0;
    bus.mem_addr    = buf_full  ? buf_addr :
                      rd_accept ? bus.cpu_addr : '0;
    bus.cpu_rd_ack  = rd_pending;
    bus.cpu_rd_data = rd_pending ? bus.mem_rdata : '0;
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      rd_pending <= 1'b0;
      hold_cnt   <= '0;
      load_err   <= 1'b0;
      byte_count <= '0;
    end else begin
      rd_pending <= rd_accept;
      hold_cnt   <= (state == ST_HOLD) ? hold_cnt + HCW'(1) : '0;
      if (buf_drop) load_err <= 1'b1;
      if ((state != ST_LOAD) && (state_nxt == ST_LOAD))
        byte_count <= '0;
      else if (buf_full && (byte_count != BC_MAX))
        byte_count <= byte_count + (MEM_AW + 1)'(1);
    end
  end

endmodule

// File: tb/tb_rom_loader_arb.sv
module tb_rom_loader_arb;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        core_reset;
  logic        load_err;
  logic [14:0] byte_count;
  int          checks = 0;
  int          errors = 0;
  int          we_count = 0;
  logic [7:0]  ram [0:16383];

  always #5 clk = ~clk;

  rom_loader_arb_if #(.MEM_AW(14)) bus ();

  rom_loader_arb #(
    .ROM_INDEX   (8'h00),
    .MEM_AW      (14),
    .HOLD_CYCLES (16)
  ) dut (
    .clk_sys    (clk),
    .reset_n    (reset_n),
    .bus        (bus.slave),
    .core_reset (core_reset),
    .load_err   (load_err),
    .byte_count (byte_count)
  );

  // Synchronous ROM/RAM model: data valid the cycle after the address.
  always @(posedge clk) begin
    if (bus.mem_we) begin
      ram[bus.mem_addr] <= bus.mem_wdata;
      we_count <= we_count + 1;
    end
    bus.mem_rdata <= ram[bus.mem_addr];
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    bus.ioctl_download = 1'b0; bus.ioctl_wr = 1'b0; bus.ioctl_addr = '0;
    bus.ioctl_dout = '0; bus.ioctl_index = '0; bus.cpu_rd_req = 1'b0; bus.cpu_addr = '0;
    cyc(); cyc();
    checks++;
    if ({core_reset, bus.ioctl_wait, bus.cpu_rd_ack, bus.mem_we, load_err} !== 5'b10000) begin
      errors++; $display("FAIL reset_flags: got %b want 10000",
        {core_reset, bus.ioctl_wait, bus.cpu_rd_ack, bus.mem_we, load_err});
    end
    checks++;
    if ({bus.mem_addr, bus.mem_wdata, bus.cpu_rd_data} !== 30'd0) begin
      errors++; $display("FAIL reset_data: got %h want 0", {bus.mem_addr, bus.mem_wdata, bus.cpu_rd_data});
    end
    checks++;
    if (byte_count !== 15'd0) begin
      errors++; $display("FAIL reset_byte_count: got %0d want 0", byte_count);
    end
    reset_n = 1'b1;
    repeat (20) cyc();
    checks++;
    if (core_reset !== 1'b1) begin
      errors++; $display("FAIL idle_core_reset: got %b want 1", core_reset);
    end
  endtask

  task automatic test_download();
    logic [7:0] d [4];
    int w0;
    int n;
    d[0] = 8'hA5; d[1] = 8'h5A; d[2] = 8'h00; d[3] = 8'hFF;
    w0 = we_count;
    bus.ioctl_index = 8'h00; bus.ioctl_download = 1'b1;
    cyc();
    checks++;
    if ({core_reset, byte_count} !== {1'b1, 15'd0}) begin
      errors++; $display("FAIL load_entry: got core_reset=%b count=%0d want 1/0", core_reset, byte_count);
    end
    for (int i = 0; i < 4; i++) begin
      bus.ioctl_addr = 25'(i); bus.ioctl_dout = d[i]; bus.ioctl_wr = 1'b1;
      cyc();
      bus.ioctl_wr = 1'b0;
      checks++;
      if ({bus.mem_we, bus.ioctl_wait, bus.mem_addr, bus.mem_wdata} !== {2'b11, 14'(i), d[i]}) begin
        errors++; $display("FAIL dl_write%0d: got we=%b wait=%b addr=%h data=%h want 1 1 %h %h", i,
          bus.mem_we, bus.ioctl_wait, bus.mem_addr, bus.mem_wdata, i, d[i]);
      end
      cyc();
    end
    checks++;
    if ({byte_count, load_err} !== {15'd4, 1'b0} || (we_count - w0) != 4) begin
      errors++; $display("FAIL dl_count: got count=%0d err=%b we=%0d want 4 0 4",
        byte_count, load_err, we_count - w0);
    end
    checks++;
    if ({ram[0], ram[1], ram[2], ram[3]} !== 32'hA55A00FF) begin
      errors++; $display("FAIL dl_ram: got %h want a55a00ff", {ram[0], ram[1], ram[2], ram[3]});
    end
    bus.ioctl_download = 1'b0;
    cyc();   // DRAIN
    cyc();   // HOLD; DRAIN left at this edge
    n = 0;
    while (core_reset === 1'b1 && n < 40) begin
      cyc(); n++;
    end
    checks++;
    if (n != 16) begin
      errors++; $display("FAIL hold_len: got %0d cycles want 16", n);
    end
  endtask

  task automatic test_read();
    logic [7:0] pat;
    logic [7:0] dor;
    pat = '0; dor = '0;
    bus.cpu_addr = 14'h0002; bus.cpu_rd_req = 1'b1;
    #1;
    checks++;
    if ({bus.mem_we, bus.mem_addr} !== {1'b0, 14'h0002}) begin
      errors++; $display("FAIL rd_accept_port: got we=%b addr=%h want 0 0002", bus.mem_we, bus.mem_addr);
    end
    for (int i = 0; i < 8; i++) begin
      cyc();
      pat[i] = bus.cpu_rd_ack;
      if (bus.cpu_rd_ack) dor = dor | bus.cpu_rd_data;
    end
    checks++;
    if (pat !== 8'b01010101) begin
      errors++; $display("FAIL rd_ack_pattern: got %b want 01010101", pat);
    end
    checks++;
    if (dor !== 8'h00) begin
      errors++; $display("FAIL rd_data_addr2: got %h want 00", dor);
    end
    bus.cpu_addr = 14'h0001;   // this cycle is an accept cycle
    cyc();
    checks++;
    if ({bus.cpu_rd_ack, bus.cpu_rd_data} !== {1'b1, 8'h5A}) begin
      errors++; $display("FAIL rd_data_addr1: got ack=%b data=%h want 1 5a", bus.cpu_rd_ack, bus.cpu_rd_data);
    end
    bus.cpu_rd_req = 1'b0;
    cyc();
    checks++;
    if (bus.cpu_rd_ack !== 1'b0) begin
      errors++; $display("FAIL rd_no_extra_ack: got %b want 0", bus.cpu_rd_ack);
    end
  endtask

  task automatic test_index_mismatch();
    logic [2:0] obs;
    obs = '0;
    bus.ioctl_download = 1'b1; bus.ioctl_index = 8'h01;
    bus.ioctl_wr = 1'b1; bus.ioctl_addr = 25'd5; bus.ioctl_dout = 8'h77;
    for (int i = 0; i < 4; i++) begin
      cyc();
      obs = obs | {core_reset, bus.ioctl_wait, bus.mem_we};
    end
    checks++;
    if (obs !== 3'b000) begin
      errors++; $display("FAIL index_mismatch: got reset/wait/we=%b want 000", obs);
    end
    bus.ioctl_wr = 1'b0; bus.ioctl_download = 1'b0;
    cyc();
  endtask

  task automatic test_restart_in_run();
    logic obs;
    obs = 1'b0;
    bus.cpu_addr = 14'h0003; bus.cpu_rd_req = 1'b1;
    bus.ioctl_index = 8'h00; bus.ioctl_download = 1'b1;
    cyc();
    checks++;
    if ({core_reset, bus.cpu_rd_ack, bus.cpu_rd_data} !== {1'b1, 1'b1, 8'hFF}) begin
      errors++; $display("FAIL restart_pending: got reset=%b ack=%b data=%h want 1 1 ff",
        core_reset, bus.cpu_rd_ack, bus.cpu_rd_data);
    end
    for (int i = 0; i < 3; i++) begin
      cyc();
      obs = obs | bus.cpu_rd_ack;
    end
    bus.cpu_rd_req = 1'b0;
    checks++;
    if (obs !== 1'b0) begin
      errors++; $display("FAIL no_read_in_load: got ack=%b want 0", obs);
    end
    checks++;
    if ({byte_count, load_err} !== 16'd0) begin
      errors++; $display("FAIL restart_clear: got count=%0d err=%b want 0 0", byte_count, load_err);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] wpat;
    int w0;
    int n;
    wpat = '0; n = 0; w0 = we_count;
    for (int i = 0; i < 8; i++) begin
      wpat[i] = bus.ioctl_wait;
      if (!bus.ioctl_wait) begin
        bus.ioctl_wr = 1'b1; bus.ioctl_addr = 25'(n); bus.ioctl_dout = 8'h10 + 8'(n); n++;
      end else begin
        bus.ioctl_wr = 1'b0;
      end
      cyc();
    end
    bus.ioctl_wr = 1'b0;
    cyc();
    checks++;
    if (wpat !== 8'b10101010) begin
      errors++; $display("FAIL b2b_wait: got %b want 10101010", wpat);
    end
    checks++;
    if ({byte_count, load_err} !== {15'd4, 1'b0} || (we_count - w0) != 4) begin
      errors++; $display("FAIL b2b_count: got count=%0d err=%b we=%0d want 4 0 4",
        byte_count, load_err, we_count - w0);
    end
    checks++;
    if ({ram[0], ram[1], ram[2], ram[3]} !== 32'h10111213) begin
      errors++; $display("FAIL b2b_ram: got %h want 10111213", {ram[0], ram[1], ram[2], ram[3]});
    end
    w0 = we_count;
    bus.ioctl_wr = 1'b1; bus.ioctl_addr = 25'd4; bus.ioctl_dout = 8'h44;
    cyc();
    bus.ioctl_addr = 25'd5; bus.ioctl_dout = 8'h55;   // ignores wait
    cyc();
    bus.ioctl_wr = 1'b0;
    cyc();
    checks++;
    if ({load_err, byte_count} !== {1'b1, 15'd5} || (we_count - w0) != 1 || ram[4] !== 8'h44) begin
      errors++; $display("FAIL b2b_overrun: got err=%b count=%0d we=%0d ram4=%h want 1 5 1 44",
        load_err, byte_count, we_count - w0, ram[4]);
    end
  endtask

  task automatic test_reset_mid();
    int w0;
    w0 = we_count;
    bus.ioctl_wr = 1'b1; bus.ioctl_addr = 25'd6; bus.ioctl_dout = 8'h66;
    cyc();
    bus.ioctl_wr = 1'b0;
    checks++;
    if (bus.mem_we !== 1'b1) begin
      errors++; $display("FAIL mid_inflight: got we=%b want 1", bus.mem_we);
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if ({core_reset, bus.ioctl_wait, bus.cpu_rd_ack, bus.mem_we, load_err} !== 5'b10000 ||
        {bus.mem_addr, bus.mem_wdata, bus.cpu_rd_data, byte_count} !== 45'd0) begin
      errors++; $display("FAIL mid_reset_outputs: got flags=%b addr=%h wd=%h rd=%h count=%0d want 10000 0 0 0 0",
        {core_reset, bus.ioctl_wait, bus.cpu_rd_ack, bus.mem_we, load_err},
        bus.mem_addr, bus.mem_wdata, bus.cpu_rd_data, byte_count);
    end
    bus.ioctl_download = 1'b0;
    cyc();
    reset_n = 1'b1;
    cyc();
    bus.ioctl_wr = 1'b1; bus.ioctl_addr = 25'd7; bus.ioctl_dout = 8'h77;
    cyc();
    bus.ioctl_wr = 1'b0;
    checks++;
    if ({bus.ioctl_wait, bus.mem_we, core_reset} !== 3'b001 || (we_count - w0) != 0) begin
      errors++; $display("FAIL mid_idle_ignore: got wait/we/reset=%b writes=%0d want 001 0",
        {bus.ioctl_wait, bus.mem_we, core_reset}, we_count - w0);
    end
    bus.ioctl_index = 8'h00; bus.ioctl_download = 1'b1;
    cyc();
    bus.ioctl_wr = 1'b1; bus.ioctl_addr = 25'd0; bus.ioctl_dout = 8'h3C;
    cyc();
    bus.ioctl_wr = 1'b0;
    checks++;
    if ({bus.mem_we, bus.mem_addr, bus.mem_wdata} !== {1'b1, 14'h0000, 8'h3C}) begin
      errors++; $display("FAIL mid_reload: got we=%b addr=%h data=%h want 1 0000 3c",
        bus.mem_we, bus.mem_addr, bus.mem_wdata);
    end
    cyc();
    checks++;
    if ({byte_count, load_err} !== {15'd1, 1'b0}) begin
      errors++; $display("FAIL mid_reload_count: got count=%0d err=%b want 1 0", byte_count, load_err);
    end
  endtask

  task automatic test_oob();
    int n;
    bus.ioctl_wr = 1'b1; bus.ioctl_addr = 25'h4000; bus.ioctl_dout = 8'h99;
    cyc();
    bus.ioctl_wr = 1'b0;
    checks++;
    if ({bus.mem_we, bus.ioctl_wait, load_err, byte_count} !== {3'b001, 15'd1}) begin
      errors++; $display("FAIL oob_4000: got we=%b wait=%b err=%b count=%0d want 0 0 1 1",
        bus.mem_we, bus.ioctl_wait, load_err, byte_count);
    end
    bus.ioctl_wr = 1'b1; bus.ioctl_addr = 25'h3FFF; bus.ioctl_dout = 8'h5C;
    cyc();
    bus.ioctl_wr = 1'b0;
    checks++;
    if ({bus.mem_we, bus.mem_addr, bus.mem_wdata} !== {1'b1, 14'h3FFF, 8'h5C}) begin
      errors++; $display("FAIL top_addr_3fff: got we=%b addr=%h data=%h want 1 3fff 5c",
        bus.mem_we, bus.mem_addr, bus.mem_wdata);
    end
    cyc();
    bus.ioctl_download = 1'b0;
    n = 0;
    while (core_reset === 1'b1 && n < 40) begin
      cyc(); n++;
    end
    checks++;
    if (byte_count !== 15'd2 || n != 18) begin
      errors++; $display("FAIL oob_finish: got count=%0d cycles_to_run=%0d want 2 18", byte_count, n);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_download();
    test_read();
    test_index_mismatch();
    test_restart_in_run();
    test_back_to_back();
    test_reset_mid();
    test_oob();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
